mac_rx_fcs_check: RTL and testbench
===================================

Name: mac_rx_fcs_check

Overview:
Receive-side counterpart of the MAC TX CRC32 generator. It takes the de-framed RX byte stream (N_SYMBOLS byte lanes per beat) and delays it by one beat. This lets it strip the trailing 4-byte FCS, which can straddle two beats. It computes CRC-32 over the remaining payload with an instance of mac_crc32, compares the result with the received FCS, and reports a per-frame status. It sits between the RX PCS/MAC de-framer and the RX user FIFO.

Parameters:
- N_SYMBOLS, 4 (cmn_params): byte lanes per beat; only 4 is supported.
- W_SYMBOL, 8: bits per lane.
- MIN_FRAME, 64: minimum legal frame length in bytes, FCS included.
- MAX_FRAME, 1522: maximum legal frame length in bytes, FCS included.
- W_LEN, 16: width of the byte counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  beat qualifier; all state advances only when 1.
- i_valid  in  N_SYMBOLS  byte-valid mask; contiguous from lane 0; 4'b1111 on every non-last beat.
- i_data  in  N_SYMBOLS x W_SYMBOL  input bytes; lane 0 is first on the wire.
- i_start  in  1  first beat of a frame.
- i_last  in  1  last beat of a frame; may coincide with i_start.
- o_valid  out  N_SYMBOLS  payload byte mask with FCS removed.
- o_data  out  N_SYMBOLS x W_SYMBOL  payload bytes.
- o_last  out  1  last payload beat.
- o_stat_valid  out  1  one-beat status strobe.
- o_fcs_ok  out  1  computed CRC equals received FCS.
- o_len_err  out  1  frame length < MIN_FRAME or > MAX_FRAME.
- o_abort  out  1  frame was cut off by a new i_start.

Behaviour:
- All outputs and state reset to 0, FSM to IDLE. Reset mid-frame drops the frame: no o_last and no status.
- When i_clk_en=0: registers hold; o_valid and o_stat_valid are forced to 0 for that cycle.
- Input beats with i_valid=0 are ignored, except when i_start or i_last is set.
- The FSM has three states: IDLE, RUN and CHECK.
- IDLE:
  - i_start with i_last=0 stores the beat in the hold register, clears the CRC (i_crc_clr), loads len=4 and moves to RUN.
  - i_start with i_last=1 means the frame is at most 4 bytes. No payload is emitted. The block moves to CHECK with fcs_ok forced to 0 and len_err=1.
- RUN, non-last beat:
  - Emit the hold word (o_valid=1111) and feed it to the CRC (i_crc_en=1111).
  - Store the new beat in the hold register; len += 4, saturating at all-ones.
- RUN, i_last with k valid bytes (k = 1..4):
  - The FCS is the last 4 bytes: hold lanes k..3 followed by input lanes 0..k-1.
  - Emit hold lanes 0..k-1 with o_valid = k-bit mask and o_last=1. This is the same beat as i_last, so there is no extra drain beat.
  - Feed the same mask to the CRC.
  - Capture the FCS as fcs[7:0] = first FCS byte ... fcs[31:24] = fourth.
  - len += k; move to CHECK.
- RUN, i_start without a preceding i_last:
  - Emit the hold word full with o_last=1; the abort flag is set.
  - Move to CHECK. The new beat is held internally and processed on the following beat as if IDLE had received it; no input beat is lost.
- CHECK, next enabled beat:
  - o_stat_valid=1 for exactly one beat.
  - o_fcs_ok = (crc_o == fcs) and no abort.
  - o_len_err = (len < MIN_FRAME) or (len > MAX_FRAME).
  - o_abort = abort flag.
  - Return to IDLE, or to RUN if a new frame was pending.
- Status follows o_last by exactly one enabled beat.
- An i_start arriving in CHECK is accepted in the same beat: the status is emitted and the new frame is loaded.
- A non-contiguous i_valid mask fires an assertion in simulation; the RTL treats it as 4'b0000.
- i_last in IDLE without i_start is ignored.

Test Plan:
- 9-byte payload "123456789" with FCS bytes 26 39 F4 CB (13 bytes, k=1) -> 2 full payload beats then a 1-byte beat with o_last; next beat o_stat_valid=1, o_fcs_ok=1, o_len_err=1.
- 60-byte payload plus correct FCS (16 beats, k=4) -> 15 payload beats, the last with o_valid=1111 and o_last=1; status o_fcs_ok=1, o_len_err=0.
- Same frame with payload byte 10 flipped -> o_fcs_ok=0, payload passed unchanged.
- Sweep k=1,2,3 with payload lengths 61, 62, 63 -> last o_valid = 0001, 0011, 0111 respectively; o_fcs_ok=1.
- Second i_start at beat 5 of a frame -> o_last on that beat, then o_abort=1 and o_fcs_ok=0; the second frame checks good.
- Random i_clk_en gaps; back-to-back frames with i_start in the CHECK beat; a 1600-byte frame; i_reset asserted mid-frame -> gaps give output identical to the gap-free run; 1600-byte frame gives o_len_err=1; after reset there is no status and the next frame is clean.

Source files
------------

// File: rtl/mac_rx_fcs_check.sv
// Receive FCS checker: delays the RX byte stream one beat so the trailing CRC-32 can be
// stripped, recomputes the CRC over the payload and reports a per-frame status strobe.

module mac_crc32 #(
    parameter int N_SYMBOLS = 4,
    parameter int W_SYMBOL  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clk_en,
    input  logic                          i_crc_clr,
    input  logic [N_SYMBOLS-1:0]          i_crc_en,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0] i_data,
    output logic [31:0]                   crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Reflected Ethernet polynomial, one byte per call, LSB first on the wire.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_d = i_crc_clr ? 32'hFFFF_FFFF : crc_q;
        for (int l = 0; l < N_SYMBOLS; l++) begin
            if (i_crc_en[l]) begin
                crc_d = crc_byte(crc_d, i_data[l*W_SYMBOL +: 8]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            crc_q <= '0;
        end else if (i_clk_en) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = ~crc_q;

endmodule

module mac_rx_fcs_check #(
    parameter int N_SYMBOLS = 4,
    parameter int W_SYMBOL  = 8,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1522,
    parameter int W_LEN     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clk_en,
    input  logic [N_SYMBOLS-1:0]          i_valid,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0] i_data,
    input  logic                          i_start,
    input  logic                          i_last,
    output logic [N_SYMBOLS-1:0]          o_valid,
    output logic [N_SYMBOLS*W_SYMBOL-1:0] o_data,
    output logic                          o_last,
    output logic                          o_stat_valid,
    output logic                          o_fcs_ok,
    output logic                          o_len_err,
    output logic                          o_abort
);

    localparam int W_WORD = N_SYMBOLS * W_SYMBOL;
    localparam logic [W_LEN-1:0] MIN_LEN = W_LEN'(MIN_FRAME);
    localparam logic [W_LEN-1:0] MAX_LEN = W_LEN'(MAX_FRAME);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK} state_e;

    state_e            state_q, state_d;
    logic              in_frame_q, in_frame_d;
    logic [W_WORD-1:0] hold_q, hold_d;
    logic [W_LEN-1:0]  len_q, len_d;
    logic [W_LEN-1:0]  stat_len_q, stat_len_d;
    logic [31:0]       fcs_q, fcs_d;
    logic              abort_q, abort_d;
    logic              pend_main_q, pend_main_d;
    logic [1:0]        tiny_cnt_q, tiny_cnt_d;

    logic                 beat_en;
    logic [N_SYMBOLS-1:0] vmask;
    logic [2:0]           k;
    logic [2*W_WORD-1:0]  fcs_window;
    logic                 tiny_set;
    logic                 crc_clr;
    logic [N_SYMBOLS-1:0] crc_en;
    logic [31:0]          crc_val;
    logic [N_SYMBOLS-1:0] out_valid;
    logic                 out_last;
    logic                 stat_valid, stat_fcs_ok, stat_len_err, stat_abort;

    function automatic logic is_contig(input logic [3:0] m);
        return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0011) ||
               (m == 4'b0111) || (m == 4'b1111);
    endfunction

    function automatic logic [2:0] count_k(input logic [3:0] m);
        case (m)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            4'b1111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [W_LEN-1:0] sat_add(input logic [W_LEN-1:0] a, input logic [2:0] b);
        logic [W_LEN:0] s;
        s = {1'b0, a} + {{(W_LEN-2){1'b0}}, b};
        return s[W_LEN] ? '1 : s[W_LEN-1:0];
    endfunction

    assign beat_en    = i_clk_en && !i_reset;
    assign vmask      = is_contig(i_valid) ? i_valid : '0;
    assign k          = count_k(vmask);
    // Bytes 0..3 are the held beat, 4..7 the incoming one; the FCS starts at byte k.
    assign fcs_window = {i_data, hold_q};

    mac_crc32 #(
        .N_SYMBOLS (N_SYMBOLS),
        .W_SYMBOL  (W_SYMBOL)
    ) u_crc (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clk_en  (i_clk_en),
        .i_crc_clr (crc_clr),
        .i_crc_en  (crc_en),
        .i_data    (hold_q),
        .crc_o     (crc_val)
    );

    always_comb begin
        state_d      = state_q;
        in_frame_d   = in_frame_q;
        hold_d       = hold_q;
        len_d        = len_q;
        stat_len_d   = stat_len_q;
        fcs_d        = fcs_q;
        abort_d      = abort_q;
        pend_main_d  = pend_main_q;
        tiny_cnt_d   = tiny_cnt_q;
        tiny_set     = 1'b0;
        crc_clr      = 1'b0;
        crc_en       = '0;
        out_valid    = '0;
        out_last     = 1'b0;
        stat_valid   = 1'b0;
        stat_fcs_ok  = 1'b0;
        stat_len_err = 1'b0;
        stat_abort   = 1'b0;

        if (beat_en) begin
            // A completed full frame reports first; a pending <=4-byte frame waits its turn.
            if (state_q == S_CHECK) begin
                stat_valid = 1'b1;
                if (pend_main_q) begin
                    stat_fcs_ok  = !abort_q && (crc_val == fcs_q);
                    stat_len_err = (stat_len_q < MIN_LEN) || (stat_len_q > MAX_LEN);
                    stat_abort   = abort_q;
                    pend_main_d  = 1'b0;
                end else begin
                    stat_len_err = 1'b1;
                    tiny_cnt_d   = tiny_cnt_q - 2'd1;
                end
            end

            if (!in_frame_q) begin
                if (i_start) begin
                    if (i_last) begin
                        tiny_set = 1'b1;
                    end else begin
                        hold_d     = i_data;
                        crc_clr    = 1'b1;
                        len_d      = W_LEN'(4);
                        in_frame_d = 1'b1;
                    end
                end
            end else if (i_start) begin
                // Frame cut short: flush the held word and start the new frame right away.
                out_valid   = '1;
                out_last    = 1'b1;
                pend_main_d = 1'b1;
                abort_d     = 1'b1;
                stat_len_d  = len_q;
                if (i_last) begin
                    tiny_set   = 1'b1;
                    in_frame_d = 1'b0;
                end else begin
                    hold_d  = i_data;
                    crc_clr = 1'b1;
                    len_d   = W_LEN'(4);
                end
            end else if (i_last) begin
                out_valid   = vmask;
                out_last    = 1'b1;
                crc_en      = vmask;
                fcs_d       = fcs_window[{k, 3'b000} +: 32];
                stat_len_d  = sat_add(len_q, k);
                len_d       = stat_len_d;
                pend_main_d = 1'b1;
                abort_d     = 1'b0;
                in_frame_d  = 1'b0;
            end else if (vmask != '0) begin
                out_valid = '1;
                crc_en    = '1;
                hold_d    = i_data;
                len_d     = sat_add(len_q, 3'd4);
            end

            if (tiny_set && (tiny_cnt_d != 2'b11)) begin
                tiny_cnt_d = tiny_cnt_d + 2'd1;
            end

            if (pend_main_d || (tiny_cnt_d != 2'd0)) begin
                state_d = S_CHECK;
            end else if (in_frame_d) begin
                state_d = S_RUN;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            in_frame_q  <= 1'b0;
            hold_q      <= '0;
            len_q       <= '0;
            stat_len_q  <= '0;
            fcs_q       <= '0;
            abort_q     <= 1'b0;
            pend_main_q <= 1'b0;
            tiny_cnt_q  <= '0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            in_frame_q  <= in_frame_d;
            hold_q      <= hold_d;
            len_q       <= len_d;
            stat_len_q  <= stat_len_d;
            fcs_q       <= fcs_d;
            abort_q     <= abort_d;
            pend_main_q <= pend_main_d;
            tiny_cnt_q  <= tiny_cnt_d;
        end
    end

    always_comb begin
        o_data = '0;
        for (int l = 0; l < N_SYMBOLS; l++) begin
            if (out_valid[l]) begin
                o_data[l*W_SYMBOL +: W_SYMBOL] = hold_q[l*W_SYMBOL +: W_SYMBOL];
            end
        end
    end

    assign o_valid      = out_valid;
    assign o_last       = out_last;
    assign o_stat_valid = stat_valid;
    assign o_fcs_ok     = stat_fcs_ok;
    assign o_len_err    = stat_len_err;
    assign o_abort      = stat_abort;

    // Upstream guarantees byte masks are packed from lane 0.
    assert property (@(posedge i_clk) disable iff (i_reset) i_clk_en |-> is_contig(i_valid));

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Bench for mac_rx_fcs_check: frames built with a reference CRC, expected payload beats and
// status words queued at drive time and checked against the DUT outputs as they appear.

module tb_mac_rx_fcs_check;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clk_en;
    logic [3:0]  i_valid;
    logic [31:0] i_data;
    logic        i_start;
    logic        i_last;
    logic [3:0]  o_valid;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_stat_valid;
    logic        o_fcs_ok;
    logic        o_len_err;
    logic        o_abort;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic [2:0]  stat_q[$];

    logic [7:0] frm [0:2047];
    int         frm_len;
    bit         gaps;

    logic [31:0] act_d;
    logic [36:0] e_pay;
    logic [2:0]  e_st;

    mac_rx_fcs_check dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_start      (i_start),
        .i_last       (i_last),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_stat_valid (o_stat_valid),
        .o_fcs_ok     (o_fcs_ok),
        .o_len_err    (o_len_err),
        .o_abort      (o_abort)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (!i_clk_en) begin
            checks++;
            if (o_valid !== 4'b0000 || o_stat_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_quiet: o_valid=%b o_stat_valid=%b, required 0000/0", o_valid, o_stat_valid);
            end
        end else begin
            if (o_valid !== 4'b0000 || o_last !== 1'b0) begin
                checks++;
                act_d = '0;
                for (int l = 0; l < 4; l++) if (o_valid[l]) act_d[l*8 +: 8] = o_data[l*8 +: 8];
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL payload_unexpected: last=%0b valid=%b data=%h, required no beat", o_last, o_valid, act_d);
                end else begin
                    e_pay = exp_q.pop_front();
                    if ({o_last, o_valid, act_d} !== e_pay) begin
                        errors++;
                        $display("FAIL payload: last=%0b valid=%b data=%h, required last=%0b valid=%b data=%h",
                                 o_last, o_valid, act_d, e_pay[36], e_pay[35:32], e_pay[31:0]);
                    end
                end
            end
            if (o_stat_valid !== 1'b0) begin
                checks++;
                if (stat_q.size() == 0) begin
                    errors++;
                    $display("FAIL status_unexpected: fcs_ok=%0b len_err=%0b abort=%0b, required no status", o_fcs_ok, o_len_err, o_abort);
                end else begin
                    e_st = stat_q.pop_front();
                    if ({o_fcs_ok, o_len_err, o_abort} !== e_st) begin
                        errors++;
                        $display("FAIL status: fcs_ok=%0b len_err=%0b abort=%0b, required fcs_ok=%0b len_err=%0b abort=%0b",
                                 o_fcs_ok, o_len_err, o_abort, e_st[2], e_st[1], e_st[0]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] frm_word(input int b, input int nbytes);
        logic [31:0] w;
        w = '0;
        for (int l = 0; l < 4; l++) if (l < nbytes) w[l*8 +: 8] = frm[4*b + l];
        return w;
    endfunction

    task automatic build_random(input int plen);
        logic [31:0] f;
        for (int i = 0; i < plen; i++) frm[i] = 8'($urandom_range(0, 255));
        f = ref_crc(plen);
        frm[plen]     = f[7:0];
        frm[plen + 1] = f[15:8];
        frm[plen + 2] = f[23:16];
        frm[plen + 3] = f[31:24];
        frm_len = plen + 4;
    endtask

    task automatic drive_beat(input logic st, input logic ls, input logic [3:0] v, input logic [31:0] d);
        i_start = st;
        i_last  = ls;
        i_valid = v;
        i_data  = d;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                i_clk_en = 1'b0;
                @(posedge i_clk);
                #1;
            end
        end
        i_clk_en = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_beat(1'b0, 1'b0, 4'b0000, 32'd0);
    endtask

    // cut_beats > 0 sends only that many beats with no i_last; the next i_start aborts it.
    task automatic send_frame(input int cut_beats, input bit fcs_good);
        int total, nb, plen, npb, cnt, nsend;
        logic [3:0] m;
        logic len_bad;
        total = frm_len;
        nb    = (total + 3) / 4;
        plen  = total - 4;
        if (cut_beats > 0) begin
            for (int b = 0; b < cut_beats; b++) exp_q.push_back({(b == cut_beats - 1), 4'hF, frm_word(b, 4)});
            len_bad = (4 * cut_beats < 64) || (4 * cut_beats > 1522);
            stat_q.push_back({1'b0, len_bad, 1'b1});
            nsend = cut_beats;
        end else begin
            if (total > 4) begin
                npb = (plen + 3) / 4;
                for (int b = 0; b < npb; b++) begin
                    cnt = plen - 4 * b;
                    if (cnt > 4) cnt = 4;
                    m = 4'((1 << cnt) - 1);
                    exp_q.push_back({(b == npb - 1), m, frm_word(b, cnt)});
                end
            end
            len_bad = (total < 64) || (total > 1522);
            stat_q.push_back({(fcs_good && total > 4), (total <= 4) || len_bad, 1'b0});
            nsend = nb;
        end
        for (int b = 0; b < nsend; b++) begin
            cnt = total - 4 * b;
            if (cnt > 4) cnt = 4;
            m = 4'((1 << cnt) - 1);
            drive_beat((b == 0), (cut_beats == 0) && (b == nb - 1), m, frm_word(b, cnt));
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_o_valid: %b, required 0000", o_valid); end
        checks++;
        if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last: %b, required 0", o_last); end
        checks++;
        if (o_stat_valid !== 1'b0) begin errors++; $display("FAIL reset_o_stat_valid: %b, required 0", o_stat_valid); end
        checks++;
        if ({o_fcs_ok, o_len_err, o_abort} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: %b, required 000", {o_fcs_ok, o_len_err, o_abort});
        end
        checks++;
        if (o_data !== 32'd0) begin errors++; $display("FAIL reset_o_data: %h, required 0", o_data); end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle(3);
    endtask

    task automatic test_crc_vector();
        logic [7:0] v [0:12];
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) frm[i] = v[i];
        frm_len = 13;
        send_frame(0, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL crc_vector_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_min_and_bad();
        build_random(60);
        send_frame(0, 1'b1);
        idle(2);
        build_random(60);
        frm[10] = frm[10] ^ 8'h01;
        send_frame(0, 1'b0);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL min_bad_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_k_sweep();
        for (int p = 61; p <= 63; p++) begin
            build_random(p);
            send_frame(0, 1'b1);
            idle(2);
        end
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL k_sweep_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_abort();
        build_random(60);
        send_frame(4, 1'b0);
        build_random(60);
        send_frame(0, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL abort_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_back_to_back();
        build_random(64 + $urandom_range(0, 40));
        send_frame(0, 1'b1);
        for (int i = 0; i < 4; i++) frm[i] = 8'($urandom_range(0, 255));
        frm_len = 4;
        send_frame(0, 1'b0);
        build_random(60 + $urandom_range(0, 3));
        send_frame(0, 1'b1);
        build_random(70);
        frm[3] = ~frm[3];
        send_frame(0, 1'b0);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_gaps();
        gaps = 1'b1;
        build_random(9);
        send_frame(0, 1'b1);
        build_random(70 + $urandom_range(0, 3));
        send_frame(0, 1'b1);
        build_random(60);
        send_frame(3, 1'b0);
        build_random(61);
        send_frame(0, 1'b1);
        idle(4);
        gaps = 1'b0;
        idle(2);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_long();
        build_random(1596);
        send_frame(0, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL long_drain: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    task automatic test_reset_mid();
        build_random(100);
        for (int b = 0; b < 5; b++) exp_q.push_back({1'b0, 4'hF, frm_word(b, 4)});
        for (int b = 0; b < 6; b++) drive_beat((b == 0), 1'b0, 4'hF, frm_word(b, 4));
        i_reset = 1'b1;
        i_start = 1'b0;
        i_last  = 1'b1;
        i_valid = 4'hF;
        i_data  = frm_word(6, 4);
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        i_reset = 1'b0;
        idle(4);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_drop: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
        build_random(64);
        send_frame(0, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_clean: pending payload=%0d status=%0d, required 0/0", exp_q.size(), stat_q.size());
        end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_clk_en = 1'b1;
        i_valid  = 4'b0000;
        i_data   = 32'd0;
        i_start  = 1'b0;
        i_last   = 1'b0;
        gaps     = 1'b0;

        test_reset();
        test_crc_vector();
        test_min_and_bad();
        test_k_sweep();
        test_abort();
        test_back_to_back();
        test_gaps();
        test_long();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
